// File: rtl/mult_div_unit.sv
// Iterative multiply (shift-and-add) / restoring divide, one operand bit per cycle.
// Optional macro MULTDIV_SIGNED_EN adds a 'sign' input for two's-complement operands.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef MULTDIV_SIGNED_EN
  input  logic             sign,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state, next_state;
  logic             busy_next, done_next;
  logic [CW-1:0]    count;
  logic             op_q, zero_q, neg_res, neg_rem;
  logic [WIDTH-1:0] mcand, acc_hi, acc_lo;
  logic             signed_op, a_neg, b_neg, b_is_zero, mag_en;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, div_shift;
  logic [WIDTH+1:0] div_diff;
  logic [WIDTH-1:0] step_hi, step_lo, res_hi, res_lo;
  logic [2*WIDTH-1:0] prod;
  logic             last_step;

`ifdef MULTDIV_SIGNED_EN
  assign signed_op = sign;
`else
  assign signed_op = 1'b0;
`endif

  // Divide by zero keeps the raw operands so the result is exactly {a, all ones}.
  always_comb begin
    b_is_zero = (b == {WIDTH{1'b0}});
    mag_en    = ~(op & b_is_zero);
    a_neg     = signed_op & a[WIDTH-1] & mag_en;
    b_neg     = signed_op & b[WIDTH-1] & mag_en;
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;
  end

  // State register with registered busy/done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= busy_next;
      done  <= done_next;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = start ? RUN : IDLE;
      RUN:     next_state = (count == {CW{1'b0}}) ? DONE : RUN;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode, registered above.
  always_comb begin
    busy_next = (next_state == RUN);
    done_next = (next_state == DONE);
  end

  assign last_step = (state == RUN) && (count == {CW{1'b0}});

  // One iteration of either algorithm from the current accumulator.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, mcand};
    if (op_q) begin
      step_hi = div_diff[WIDTH+1] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
      step_lo = {acc_lo[WIDTH-2:0], ~div_diff[WIDTH+1]};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  // Sign correction applied to the final iteration only.
  always_comb begin
    prod = {step_hi, step_lo};
    if (op_q) begin
      res_lo = neg_res ? -step_lo : step_lo;
      res_hi = neg_rem ? -step_hi : step_hi;
    end else begin
      {res_hi, res_lo} = neg_res ? -prod : prod;
    end
  end

  // Operand capture, iteration and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= {CW{1'b0}};
      op_q     <= 1'b0;
      zero_q   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      mcand    <= {WIDTH{1'b0}};
      acc_hi   <= {WIDTH{1'b0}};
      acc_lo   <= {WIDTH{1'b0}};
      hi       <= {WIDTH{1'b0}};
      lo       <= {WIDTH{1'b0}};
      div_zero <= 1'b0;
    end else if (state == IDLE && start) begin
      count   <= CW'(WIDTH - 1);
      op_q    <= op;
      zero_q  <= op & b_is_zero;
      neg_res <= a_neg ^ b_neg;
      neg_rem <= a_neg & op;
      mcand   <= op ? b_mag : a_mag;
      acc_hi  <= {WIDTH{1'b0}};
      acc_lo  <= op ? a_mag : b_mag;
    end else if (state == RUN) begin
      acc_hi <= step_hi;
      acc_lo <= step_lo;
      if (last_step) begin
        hi       <= res_hi;
        lo       <= res_lo;
        div_zero <= zero_q;
      end else begin
        count <= count - CW'(1);
      end
    end else if (state == DONE) begin
      div_zero <= 1'b0;
    end else begin
      count <= count;
    end
  end

endmodule
